// File: rtl/instruction_fetch_unit.sv
// Fetch-side PC owner: reads instruction memory at pc over req/ack and hands the word downstream
// over valid/ready. Define IFU_PERF_COUNT_EN to add saturating fetch/stall counters.
module instruction_fetch_unit #(
  parameter int unsigned                INSTR_ADDR_SIZE = 32,
  parameter int unsigned                INSTR_WIDTH     = 32,
  parameter logic [INSTR_ADDR_SIZE-1:0] RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_en_i,
  output logic                       imem_req_o,
  output logic [INSTR_ADDR_SIZE-1:0] imem_addr_o,
  input  logic                       imem_ack_i,
  input  logic [INSTR_WIDTH-1:0]     imem_rdata_i,
  output logic [INSTR_ADDR_SIZE-1:0] current_pc_o,
  input  logic [INSTR_ADDR_SIZE-1:0] next_pc_i,
  output logic                       instr_valid_o,
  input  logic                       instr_ready_i,
  output logic [INSTR_WIDTH-1:0]     instr_o,
  output logic [INSTR_ADDR_SIZE-1:0] instr_pc_o
`ifdef IFU_PERF_COUNT_EN
  ,
  output logic [31:0]                fetch_count_o,
  output logic [31:0]                stall_count_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e                     state_q;
  logic [INSTR_ADDR_SIZE-1:0] pc_q;
  logic [INSTR_WIDTH-1:0]     instr_q;
  logic                       req_q;
  logic                       valid_q;

  // Fetch FSM; req/valid are registered alongside the state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fetch_en_i) begin
            state_q <= S_WAIT;
            req_q   <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_ack_i) begin
            instr_q <= imem_rdata_i;
            state_q <= S_HOLD;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        S_HOLD: begin
          // next_pc is taken verbatim; any wrap-around is the PC-update logic's business.
          if (instr_ready_i) begin
            pc_q    <= next_pc_i;
            valid_q <= 1'b0;
            if (fetch_en_i) begin
              state_q <= S_WAIT;
              req_q   <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign current_pc_o  = pc_q;
  assign instr_pc_o    = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;

`ifdef IFU_PERF_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic        handshake_s;
  logic        stall_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

  assign handshake_s = valid_q && instr_ready_i;
  assign stall_s     = (state_q == S_WAIT) && !imem_ack_i;

  // Next values of the saturating performance counters.
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (handshake_s) begin
      fetch_count_d = sat_inc(fetch_count_q);
    end else begin
      fetch_count_d = fetch_count_q;
    end
    if (stall_s) begin
      stall_count_d = sat_inc(stall_count_q);
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count_o = fetch_count_q;
  assign stall_count_o = stall_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed sequence with randomized latencies, stalls and
// next_pc choices, checked at transaction level against a PC / memory-content model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] current_pc;
  logic [31:0] next_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef IFU_PERF_COUNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_pc;
  logic [31:0] salt;
  int          exp_fetch;
  int          exp_stall;

  instruction_fetch_unit #(
    .INSTR_ADDR_SIZE(32),
    .INSTR_WIDTH    (32),
    .RESET_PC       (RESET_PC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_en_i   (fetch_en),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (imem_ack),
    .imem_rdata_i (imem_rdata),
    .current_pc_o (current_pc),
    .next_pc_i    (next_pc),
    .instr_valid_o(instr_valid),
    .instr_ready_i(instr_ready),
    .instr_o      (instr),
    .instr_pc_o   (instr_pc)
`ifdef IFU_PERF_COUNT_EN
    ,
    .fetch_count_o(fetch_count),
    .stall_count_o(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory content is a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ salt ^ a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag, input logic req, input logic valid);
    chk({tag, "_req"},   {31'd0, imem_req},    {31'd0, req});
    chk({tag, "_valid"}, {31'd0, instr_valid}, {31'd0, valid});
    chk({tag, "_addr"},  imem_addr,  exp_pc);
    chk({tag, "_cpc"},   current_pc, exp_pc);
    chk({tag, "_ipc"},   instr_pc,   exp_pc);
  endtask

  // One full transaction starting in the read-request phase: lat ack-less cycles, then ack,
  // hold stalled cycles with spurious acks, then a handshake supplying np.
  task automatic fetch_one(input int lat, input int hold, input logic [31:0] np, input logic fe);
    logic [31:0] w;
    for (int k = 0; k < lat; k++) begin
      chk_out("wait", 1'b1, 1'b0);
      imem_ack    = 1'b0;
      fetch_en    = 1'($urandom_range(0, 1));
      instr_ready = 1'($urandom_range(0, 1));
      next_pc     = $urandom;
      exp_stall++;
      step();
    end
    chk_out("ack_cycle", 1'b1, 1'b0);
    w           = mem_word(exp_pc);
    imem_ack    = 1'b1;
    imem_rdata  = w;
    instr_ready = 1'($urandom_range(0, 1));
    next_pc     = $urandom;
    step();
    imem_ack = 1'b0;
    chk_out("hold", 1'b0, 1'b1);
    chk("instr", instr, w);
    for (int r = 0; r < hold; r++) begin
      instr_ready = 1'b0;
      imem_ack    = 1'b1;
      imem_rdata  = ~w;
      fetch_en    = 1'($urandom_range(0, 1));
      next_pc     = $urandom;
      step();
      imem_ack = 1'b0;
      chk_out("stall", 1'b0, 1'b1);
      chk("instr_stall", instr, w);
    end
    instr_ready = 1'b1;
    next_pc     = np;
    fetch_en    = fe;
    step();
    instr_ready = 1'b0;
    exp_pc      = np;
    exp_fetch++;
    chk_out("post_hs", fe, 1'b0);
  endtask

  // From idle: one cycle of ignored ack/ready, then start fetching again.
  task automatic restart();
    fetch_en    = 1'b0;
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    next_pc     = $urandom;
    step();
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    chk_out("idle", 1'b0, 1'b0);
    fetch_en = 1'b1;
    step();
    chk_out("start", 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] np;
    logic        fe;
    salt        = $urandom;
    rst_n       = 1'b0;
    fetch_en    = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'd0;
    next_pc     = 32'd0;
    instr_ready = 1'b0;
    exp_pc      = RESET_PC;
    exp_fetch   = 0;
    exp_stall   = 0;
    step();
    step();
    chk_out("reset", 1'b0, 1'b0);
    chk("reset_instr", instr, 32'd0);
    #2 rst_n = 1'b1;
    step();
    chk_out("idle_after_reset", 1'b0, 1'b0);
    fetch_en = 1'b1;
    step();
    chk_out("first_req", 1'b1, 1'b0);

    // Back-to-back sequential fetches with zero-latency memory.
    for (int i = 0; i < 4; i++) fetch_one(0, 0, exp_pc + 32'd1, 1'b1);
    // Slow memory, then a long downstream stall.
    fetch_one(3, 0, exp_pc + 32'd1, 1'b1);
    fetch_one(0, 4, exp_pc + 32'd1, 1'b1);
    // Jump from pc 5 to 0x40.
    fetch_one(0, 0, 32'd5, 1'b1);
    fetch_one(1, 0, 32'h0000_0040, 1'b1);
    fetch_one(0, 0, 32'h0000_0041, 1'b1);
    // All-ones wraps to zero through next_pc.
    fetch_one(0, 0, 32'hFFFF_FFFF, 1'b1);
    fetch_one(0, 0, exp_pc + 32'd1, 1'b0);
    restart();

    // Randomized transactions.
    for (int i = 0; i < 20; i++) begin
      np = ($urandom_range(0, 1) == 0) ? exp_pc + 32'd1 : $urandom;
      fe = 1'($urandom_range(0, 1));
      fetch_one($urandom_range(0, 3), $urandom_range(0, 2), np, fe);
      if (!fe) restart();
    end

    // Reset while a read to pc 7 is outstanding; acks during and after reset are ignored.
    fetch_one(0, 0, 32'd7, 1'b1);
    #2;
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    exp_pc = RESET_PC;
    chk_out("rst_async", 1'b0, 1'b0);
    chk("rst_instr", instr, 32'd0);
    step();
    chk_out("rst_held", 1'b0, 1'b0);
    fetch_en = 1'b0;
    #2 rst_n = 1'b1;
    step();
    chk_out("late_ack", 1'b0, 1'b0);
    chk("late_ack_instr", instr, 32'd0);
    imem_ack  = 1'b0;
    exp_fetch = 0;
    exp_stall = 0;
    fetch_en  = 1'b1;
    step();
    chk_out("restart_after_rst", 1'b1, 1'b0);

    // Ten fetches each acked on the second request cycle.
    for (int i = 0; i < 10; i++) fetch_one(1, 0, exp_pc + 32'd1, (i != 9));
`ifdef IFU_PERF_COUNT_EN
    chk("fetch_count", fetch_count, 32'(exp_fetch));
    chk("stall_count", stall_count, 32'(exp_stall));
    chk("fetch_count_10", fetch_count, 32'd10);
    chk("stall_count_10", stall_count, 32'd10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
